// File: rtl/sobel_3x3_8bit.sv
// 3x3 Sobel |Gx|+|Gy| edge detector; define SOBEL_MAG_OUT_EN for saturated magnitude output.
// Latency 4 clk, 1 pixel/clk, no backpressure; threshold latched at pixel (0,0) of each frame.
module sobel_3x3_8bit #(
  parameter logic [11:0] H_DISP     = 12'd480,
  parameter logic [11:0] V_DISP     = 12'd272,
  parameter logic [7:0]  THRESH_RST = 8'd128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       matrix_vld,
  input  logic [7:0] matrix_11,
  input  logic [7:0] matrix_12,
  input  logic [7:0] matrix_13,
  input  logic [7:0] matrix_21,
  input  logic [7:0] matrix_22,
  input  logic [7:0] matrix_23,
  input  logic [7:0] matrix_31,
  input  logic [7:0] matrix_32,
  input  logic [7:0] matrix_33,
  input  logic [7:0] threshold,
  output logic       dout_vld,
  output logic [7:0] dout,
  output logic       dout_sof,
  output logic       dout_eol
);

  logic [11:0] cnt_col_q, cnt_col_d, cnt_row_q, cnt_row_d;
  logic [7:0]  thr_q, thr_d;
  logic        sof_in, eol_in, col_last;
  logic [7:0]  thr_eff;

  logic [9:0]  gx_p_q, gx_p_d, gx_n_q, gx_n_d, gy_p_q, gy_p_d, gy_n_q, gy_n_d;
  logic [9:0]  abs_gx_q, abs_gx_d, abs_gy_q, abs_gy_d;
  logic [10:0] mag_q, mag_d;
  logic [7:0]  dout_q, dout_d;
  logic [7:0]  thr1_q, thr2_q, thr3_q;
  logic [3:0]  vld_sr_q, vld_sr_d, sof_sr_q, sof_sr_d, eol_sr_q, eol_sr_d;

  // The threshold travels with every pixel so the first pixel of a frame
  // already sees the value sampled for it, whatever the frame size.
  always_comb begin
    cnt_col_d = cnt_col_q;
    cnt_row_d = cnt_row_q;
    thr_d     = thr_q;
    col_last  = (cnt_col_q == H_DISP - 12'd1);
    sof_in    = matrix_vld && (cnt_col_q == 12'd0) && (cnt_row_q == 12'd0);
    eol_in    = matrix_vld && col_last;
    thr_eff   = sof_in ? threshold : thr_q;
    if (matrix_vld) begin
      if (sof_in) thr_d = threshold;
      if (col_last) begin
        cnt_col_d = 12'd0;
        cnt_row_d = (cnt_row_q == V_DISP - 12'd1) ? 12'd0 : cnt_row_q + 12'd1;
      end else begin
        cnt_col_d = cnt_col_q + 12'd1;
      end
    end

    gx_p_d = {2'b0, matrix_13} + {1'b0, matrix_23, 1'b0} + {2'b0, matrix_33};
    gx_n_d = {2'b0, matrix_11} + {1'b0, matrix_21, 1'b0} + {2'b0, matrix_31};
    gy_p_d = {2'b0, matrix_31} + {1'b0, matrix_32, 1'b0} + {2'b0, matrix_33};
    gy_n_d = {2'b0, matrix_11} + {1'b0, matrix_12, 1'b0} + {2'b0, matrix_13};

    abs_gx_d = (gx_p_q >= gx_n_q) ? gx_p_q - gx_n_q : gx_n_q - gx_p_q;
    abs_gy_d = (gy_p_q >= gy_n_q) ? gy_p_q - gy_n_q : gy_n_q - gy_p_q;
    mag_d    = {1'b0, abs_gx_q} + {1'b0, abs_gy_q};

`ifdef SOBEL_MAG_OUT_EN
    dout_d = (mag_q > 11'd255) ? 8'hFF : mag_q[7:0];
`else
    dout_d = (mag_q > {3'b0, thr3_q}) ? 8'hFF : 8'h00;
`endif

    vld_sr_d = {vld_sr_q[2:0], matrix_vld};
    sof_sr_d = {sof_sr_q[2:0], sof_in};
    eol_sr_d = {eol_sr_q[2:0], eol_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_col_q <= 12'd0;
      cnt_row_q <= 12'd0;
      thr_q     <= THRESH_RST;
      gx_p_q    <= 10'd0;
      gx_n_q    <= 10'd0;
      gy_p_q    <= 10'd0;
      gy_n_q    <= 10'd0;
      abs_gx_q  <= 10'd0;
      abs_gy_q  <= 10'd0;
      mag_q     <= 11'd0;
      dout_q    <= 8'd0;
      thr1_q    <= 8'd0;
      thr2_q    <= 8'd0;
      thr3_q    <= 8'd0;
      vld_sr_q  <= 4'd0;
      sof_sr_q  <= 4'd0;
      eol_sr_q  <= 4'd0;
    end else begin
      cnt_col_q <= cnt_col_d;
      cnt_row_q <= cnt_row_d;
      thr_q     <= thr_d;
      gx_p_q    <= gx_p_d;
      gx_n_q    <= gx_n_d;
      gy_p_q    <= gy_p_d;
      gy_n_q    <= gy_n_d;
      abs_gx_q  <= abs_gx_d;
      abs_gy_q  <= abs_gy_d;
      mag_q     <= mag_d;
      dout_q    <= dout_d;
      thr1_q    <= thr_eff;
      thr2_q    <= thr1_q;
      thr3_q    <= thr2_q;
      vld_sr_q  <= vld_sr_d;
      sof_sr_q  <= sof_sr_d;
      eol_sr_q  <= eol_sr_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = vld_sr_q[3];
  assign dout_sof = sof_sr_q[3];
  assign dout_eol = eol_sr_q[3];

endmodule
